rf_host_controller: RTL and testbench



---
 rtl/rf_host_controller.sv | 206 ++++++++++++++++++++
 tb/tb_rf_host_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_host_controller.sv
// Host-side controller for the RF transceiver. It drives the M0/M1 mode pins,
// tracks AUX, and runs config, query and reset command packets over a byte UART handshake.
module rf_host_controller #(
  parameter int                    DATA_WIDTH         = 8,
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_1      = 8'hC0,
  parameter logic [DATA_WIDTH-1:0] RET_CONFIG_DETECT  = 8'hC1,
  parameter logic [DATA_WIDTH-1:0] RET_VERSION_DETECT = 8'hC3,
  parameter logic [DATA_WIDTH-1:0] RESET_DETECT       = 8'hC4,
  parameter int                    MODE_SETTLE_CLK    = 20000,
  parameter int                    TIMEOUT_CLK        = 1000000
) (
  input  logic                    internal_clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode_sel,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_op,
  input  logic [5*DATA_WIDTH-1:0] cmd_cfg,
  output logic                    cmd_ready,
  output logic                    resp_valid,
  output logic [6*DATA_WIDTH-1:0] resp_data,
  output logic [1:0]              resp_err,
  output logic                    busy,
  output logic                    M0,
  output logic                    M1,
  input  logic                    AUX,
  output logic [DATA_WIDTH-1:0]   data_to_uart,
  output logic                    TX_use,
  input  logic                    TX_flag,
  input  logic [DATA_WIDTH-1:0]   data_from_uart,
  input  logic                    RX_flag,
  output logic                    RX_use
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_AUX1, S_SET_M3, S_WAIT_AUX2, S_SETTLE, S_SEND,
    S_RX, S_RST_WAIT, S_RESTORE, S_WAIT_AUX3, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_WR_CFG, OP_RD_CFG, OP_RD_VER, OP_RESET} op_t;

  localparam int CNT_MAX = (TIMEOUT_CLK > MODE_SETTLE_CLK) ? TIMEOUT_CLK : MODE_SETTLE_CLK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CLK - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(MODE_SETTLE_CLK - 1);

  state_t                    r_state, w_next;
  op_t                       r_op;
  logic [5*DATA_WIDTH-1:0]   r_cfg;
  logic [6*DATA_WIDTH-1:0]   r_data;
  logic [1:0]                r_err;
  logic [1:0]                r_m;
  logic                      r_aux_s1, r_aux_s2;
  logic                      r_aux_low_seen;
  logic [CNT_W-1:0]          r_cnt;
  logic [2:0]                r_tx_idx, r_rx_idx;
  logic                      r_tx_guard, r_rx_guard;

  logic                      w_tx_use, w_rx_use;
  logic                      w_timeout, w_counting, w_tmo_err;
  logic [2:0]                w_tx_len, w_rx_len;
  logic [DATA_WIDTH-1:0]     w_tx_byte, w_rx_head;

  assign w_tx_len   = (r_op == OP_WR_CFG) ? 3'd6 : 3'd3;
  assign w_rx_len   = (r_op == OP_RD_CFG) ? 3'd6 : 3'd4;
  assign w_rx_head  = (r_op == OP_RD_CFG) ? HEAD_DETECT_1 : RET_VERSION_DETECT;
  assign w_timeout  = (r_cnt == TMO_LAST);
  assign w_counting = (r_state inside {S_WAIT_AUX1, S_WAIT_AUX2, S_SETTLE,
                                       S_RX, S_RST_WAIT, S_WAIT_AUX3});

  always_comb begin
    w_tx_byte = RESET_DETECT;
    unique case (r_op)
      OP_WR_CFG: begin
        case (r_tx_idx)
          3'd0:    w_tx_byte = HEAD_DETECT_1;
          3'd1:    w_tx_byte = r_cfg[5*DATA_WIDTH-1 -: DATA_WIDTH];
          3'd2:    w_tx_byte = r_cfg[4*DATA_WIDTH-1 -: DATA_WIDTH];
          3'd3:    w_tx_byte = r_cfg[3*DATA_WIDTH-1 -: DATA_WIDTH];
          3'd4:    w_tx_byte = r_cfg[2*DATA_WIDTH-1 -: DATA_WIDTH];
          default: w_tx_byte = r_cfg[DATA_WIDTH-1:0];
        endcase
      end
      OP_RD_CFG: w_tx_byte = RET_CONFIG_DETECT;
      OP_RD_VER: w_tx_byte = RET_VERSION_DETECT;
      OP_RESET:  w_tx_byte = RESET_DETECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a variable unassigned (no inferred latch).
    w_next    = r_state;
    w_tmo_err = 1'b0;
    unique case (r_state)
      S_IDLE:      if (cmd_valid) w_next = S_WAIT_AUX1;
      S_WAIT_AUX1: if (r_aux_s2) w_next = S_SET_M3;
                   else if (w_timeout) begin w_next = S_RESTORE; w_tmo_err = 1'b1; end
      S_SET_M3:    w_next = S_WAIT_AUX2;
      S_WAIT_AUX2: if (r_aux_s2) w_next = S_SETTLE;
                   else if (w_timeout) begin w_next = S_RESTORE; w_tmo_err = 1'b1; end
      S_SETTLE:    if (r_cnt == SETTLE_LAST) w_next = S_SEND;
      S_SEND: begin
        if (w_tx_use && (r_tx_idx == w_tx_len - 3'd1)) begin
          unique case (r_op)
            OP_WR_CFG:            w_next = S_RESTORE;
            OP_RD_CFG, OP_RD_VER: w_next = S_RX;
            OP_RESET:             w_next = S_RST_WAIT;
          endcase
        end
      end
      S_RX:        if (w_rx_use && (r_rx_idx == w_rx_len - 3'd1)) w_next = S_RESTORE;
                   else if (w_timeout) begin w_next = S_RESTORE; w_tmo_err = 1'b1; end
      S_RST_WAIT:  if (r_aux_low_seen && r_aux_s2) w_next = S_RESTORE;
                   else if (w_timeout) begin w_next = S_RESTORE; w_tmo_err = 1'b1; end
      S_RESTORE:   w_next = S_WAIT_AUX3;
      S_WAIT_AUX3: if (r_aux_s2) w_next = S_DONE;
                   else if (w_timeout) begin w_next = S_DONE; w_tmo_err = 1'b1; end
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // The guard flops keep a one-cycle gap after each UART handshake.
  always_comb begin
    cmd_ready    = (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    resp_valid   = (r_state == S_DONE);
    w_tx_use     = (r_state == S_SEND) && TX_flag && !r_tx_guard;
    w_rx_use     = (r_state == S_RX) && RX_flag && !r_rx_guard;
    data_to_uart = (r_state == S_SEND) ? w_tx_byte : '0;
  end

  assign TX_use    = w_tx_use;
  assign RX_use    = w_rx_use;
  assign resp_data = r_data;
  assign resp_err  = r_err;
  assign M1        = r_m[1];
  assign M0        = r_m[0];

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aux_s1       <= 1'b0;
      r_aux_s2       <= 1'b0;
      r_aux_low_seen <= 1'b0;
      r_op           <= OP_WR_CFG;
      r_cfg          <= '0;
      r_data         <= '0;
      r_err          <= 2'd0;
      r_m            <= 2'b00;
      r_cnt          <= '0;
      r_tx_idx       <= 3'd0;
      r_rx_idx       <= 3'd0;
      r_tx_guard     <= 1'b0;
      r_rx_guard     <= 1'b0;
    end else begin
      r_aux_s1   <= AUX;
      r_aux_s2   <= r_aux_s1;
      r_tx_guard <= w_tx_use;
      r_rx_guard <= w_rx_use;

      // Reload on every state change and every received byte.
      if ((r_state != w_next) || w_rx_use) r_cnt <= '0;
      else if (w_counting)                 r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == S_RST_WAIT) begin
        if (!r_aux_s2) r_aux_low_seen <= 1'b1;
      end else begin
        r_aux_low_seen <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_m <= mode_sel;
          if (cmd_valid) begin
            r_op     <= op_t'(cmd_op);
            r_cfg    <= cmd_cfg;
            r_data   <= '0;
            r_err    <= 2'd0;
            r_tx_idx <= 3'd0;
            r_rx_idx <= 3'd0;
          end
        end
        S_SET_M3:  r_m <= 2'b11;
        S_RESTORE: r_m <= mode_sel;
        default: ;
      endcase

      if (w_tx_use) r_tx_idx <= r_tx_idx + 3'd1;

      if (w_rx_use) begin
        r_rx_idx <= r_rx_idx + 3'd1;
        r_data   <= {r_data[5*DATA_WIDTH-1:0], data_from_uart};
        if ((r_rx_idx == 3'd0) && (data_from_uart != w_rx_head)) r_err <= 2'd2;
      end

      // Timeout overrides a bad-header code.
      if (w_tmo_err) r_err <= 2'd1;
    end
  end

endmodule

// File: tb/tb_rf_host_controller.sv
// Scoreboard bench for rf_host_controller: directed commands push expected TX
// bytes and responses into queues, and a monitor pops and compares them.
module tb_rf_host_controller;

  localparam int TMO    = 100;
  localparam int SETTLE = 10;

  typedef struct {
    logic [47:0] data;
    logic [1:0]  err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode_sel;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [39:0] cmd_cfg;
  logic        cmd_ready, resp_valid, busy, M0, M1;
  logic [47:0] resp_data;
  logic [1:0]  resp_err;
  logic        AUX;
  logic [7:0]  data_to_uart, data_from_uart;
  logic        TX_use, TX_flag, RX_flag, RX_use;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_count = 0, rx_count = 0, resp_count = 0;
  int last_tx_cyc = 0, resp_cyc = 0;
  logic [1:0] resp_m;
  int tx_busy_cycles = 2;

  logic [7:0] exp_tx_q[$];
  resp_t      exp_resp_q[$];
  logic [7:0] rx_q[$];

  rf_host_controller #(.MODE_SETTLE_CLK(SETTLE), .TIMEOUT_CLK(TMO)) dut (
    .internal_clk(clk), .rst_n(rst_n), .mode_sel(mode_sel),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_cfg(cmd_cfg),
    .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .M0(M0), .M1(M1), .AUX(AUX),
    .data_to_uart(data_to_uart), .TX_use(TX_use), .TX_flag(TX_flag),
    .data_from_uart(data_from_uart), .RX_flag(RX_flag), .RX_use(RX_use)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART model: inputs change 1 ns after posedge; handshakes are sampled at negedge.
  initial begin : uart_model
    int   tx_hold;
    int   rx_gap;
    logic tx_seen, rx_seen;
    tx_hold = 0; rx_gap = 0;
    TX_flag = 1'b1; RX_flag = 1'b0; data_from_uart = 8'h00;
    forever begin
      @(negedge clk);
      tx_seen = TX_use;
      rx_seen = RX_use;
      @(posedge clk); #1;
      if (tx_seen) tx_hold = tx_busy_cycles;
      else if (tx_hold > 0) tx_hold--;
      TX_flag = (tx_hold == 0);
      if (rx_seen && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        rx_gap = 1;
      end else if (rx_gap > 0) begin
        rx_gap--;
      end
      RX_flag        = (rx_gap == 0) && (rx_q.size() > 0);
      data_from_uart = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  initial begin : monitor
    logic       prev_tx;
    logic [7:0] exp_b;
    resp_t      exp_r;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_tx = 1'b0;
      end else begin
        if (TX_use) begin
          tx_count++;
          last_tx_cyc = cyc;
          check("tx_flag_high", 64'(TX_flag), 64'd1);
          check("tx_guard_gap", 64'(prev_tx), 64'd0);
          check("tx_mode_pins", 64'({M1, M0}), 64'd3);
          if (exp_tx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: actual=%0h required=none", data_to_uart);
          end else begin
            exp_b = exp_tx_q.pop_front();
            check("tx_byte", 64'(data_to_uart), 64'(exp_b));
          end
        end
        prev_tx = TX_use;
        if (RX_use) rx_count++;
        if (resp_valid) begin
          resp_count++;
          resp_cyc = cyc;
          resp_m   = {M1, M0};
          if (exp_resp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL resp_unexpected: actual=%0h/%0d required=none", resp_data, resp_err);
          end else begin
            exp_r = exp_resp_q.pop_front();
            check("resp_data", 64'(resp_data), 64'(exp_r.data));
            check("resp_err", 64'(resp_err), 64'(exp_r.err));
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [39:0] cfg);
    @(posedge clk); #1;
    cmd_op = op; cmd_cfg = cfg; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b[]);
    foreach (b[i]) exp_tx_q.push_back(b[i]);
  endtask

  task automatic push_resp(input logic [47:0] d, input logic [1:0] e);
    resp_t r;
    r.data = d; r.err = e;
    exp_resp_q.push_back(r);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n = 0;
    while (resp_count < target && n < budget) begin @(negedge clk); n++; end
    if (resp_count < target) begin
      checks++; failures++;
      $display("FAIL resp_wait: actual=%0d responses required=%0d within %0d cycles", resp_count, target, budget);
    end
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_count < target && n < budget) begin @(negedge clk); n++; end
    if (tx_count < target) begin
      checks++; failures++;
      $display("FAIL tx_wait: actual=%0d bytes required=%0d within %0d cycles", tx_count, target, budget);
    end
  endtask

  initial begin : stim
    int rx0, tx0, r0, aux_rise_cyc;
    rst_n = 1'b0; mode_sel = 2'b00; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_cfg = '0; AUX = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp", 64'({resp_data, resp_err}), 64'd0);
    check("rst_uart", 64'({TX_use, RX_use, data_to_uart}), 64'd0);
    check("rst_mode", 64'({M1, M0}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle mode tracking: one cycle of latency from mode_sel to the pins.
    @(posedge clk); #1 mode_sel = 2'b10;
    @(negedge clk); check("idle_mode_latency", 64'({M1, M0}), 64'd0);
    @(negedge clk); check("idle_mode_track", 64'({M1, M0}), 64'd2);
    @(posedge clk); #1 mode_sel = 2'b00;
    repeat (2) @(negedge clk);

    // Read version. The response bytes are presented early, so they are stray until RX.
    tx_busy_cycles = 2; rx0 = rx_count; tx0 = tx_count;
    rx_q = '{8'hC3, 8'h32, 8'h27, 8'h02};
    push_tx('{8'hC3, 8'hC3, 8'hC3});
    push_resp(48'h0000C3322702, 2'd0);
    issue(2'd2, '0);
    wait_resp(1, 500);
    check("ver_tx_count", 64'(tx_count - tx0), 64'd3);
    check("ver_rx_count", 64'(rx_count - rx0), 64'd4);
    check("ver_mode_restored", 64'(resp_m), 64'd0);

    // Write config. A stray RX byte must stay unconsumed.
    tx_busy_cycles = 3; rx0 = rx_count;
    rx_q = '{8'hAA};
    push_tx('{8'hC0, 8'h00, 8'h00, 8'h1A, 8'h17, 8'h44});
    push_resp(48'h0, 2'd0);
    issue(2'd0, 40'h0000_1A17_44);
    wait_resp(2, 500);
    check("wr_no_rx_use", 64'(rx_count - rx0), 64'd0);
    rx_q.delete();

    // Read config with bad header. TX_flag stays high, so only the guard spaces TX_use.
    tx_busy_cycles = 0; rx0 = rx_count;
    rx_q = '{8'hC2, 8'h00, 8'h00, 8'h1A, 8'h17, 8'h44};
    push_tx('{8'hC1, 8'hC1, 8'hC1});
    push_resp(48'hC200001A1744, 2'd2);
    issue(2'd1, '0);
    wait_resp(3, 500);
    check("badhdr_rx_count", 64'(rx_count - rx0), 64'd6);

    // Timeout in RX. The decision falls TMO cycles after the last TX_use,
    // then RESTORE, WAIT_AUX3 and DONE each add one cycle.
    tx_busy_cycles = 2; mode_sel = 2'b01;
    push_tx('{8'hC3, 8'hC3, 8'hC3});
    push_resp(48'h0, 2'd1);
    issue(2'd2, '0);
    wait_resp(4, 500);
    check("tmo_latency", 64'(resp_cyc - last_tx_cyc), 64'(TMO + 3));
    check("tmo_mode_restored", 64'(resp_m), 64'd1);
    @(posedge clk); #1 mode_sel = 2'b00;

    // Reset op: AUX drops low for 50 cycles after the last byte and then rises.
    tx0 = tx_count;
    push_tx('{8'hC4, 8'hC4, 8'hC4});
    push_resp(48'h0, 2'd0);
    issue(2'd3, '0);
    wait_tx(tx0 + 3, 300);
    r0 = resp_count;
    @(posedge clk); #1 AUX = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("rst_op_no_early_done", 64'(resp_count), 64'(r0));
    AUX = 1'b1; aux_rise_cyc = cyc;
    wait_resp(r0 + 1, 300);
    check("rst_op_after_aux", 64'(resp_cyc > aux_rise_cyc), 64'd1);

    // Reset op with AUX stuck high: it times out in RST_WAIT.
    push_tx('{8'hC4, 8'hC4, 8'hC4});
    push_resp(48'h0, 2'd1);
    issue(2'd3, '0);
    wait_resp(r0 + 2, 500);

    // cmd_valid while busy is ignored, and no second command is queued.
    r0 = resp_count;
    push_tx('{8'hC0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A});
    push_resp(48'h0, 2'd0);
    issue(2'd0, 40'h12_3456_789A);
    repeat (3) @(posedge clk);
    #1 cmd_op = 2'd2; cmd_valid = 1'b1;
    @(negedge clk);
    check("busy_cmd_ready_low", 64'(cmd_ready), 64'd0);
    check("busy_high", 64'(busy), 64'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_resp(r0 + 1, 500);
    repeat (20) @(negedge clk);
    check("busy_no_extra_resp", 64'(resp_count), 64'(r0 + 1));
    check("busy_back_idle", 64'(busy), 64'd0);
    check("sb_tx_drained", 64'(exp_tx_q.size()), 64'd0);
    check("sb_resp_drained", 64'(exp_resp_q.size()), 64'd0);

    // Abort: reset lands mid-SEND and must not produce a response.
    tx_busy_cycles = 4; tx0 = tx_count; r0 = resp_count;
    push_tx('{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    issue(2'd0, 40'h01_0203_0405);
    wait_tx(tx0 + 1, 300);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_uart", 64'({TX_use, RX_use, data_to_uart}), 64'd0);
    check("abort_resp", 64'({resp_valid, resp_data, resp_err}), 64'd0);
    check("abort_mode", 64'({M1, M0}), 64'd0);
    exp_tx_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_resp", 64'(resp_count), 64'(r0));
    check("abort_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
